keypad_scanner: RTL and testbench

Column-drive side of the elevator call/car keypad matrix. Drives one column of the 4x4 matrix at a time and samples the four row lines after a settle interval. Each key is debounced across consecutive scans. Every new press is reported as a 4-bit key code over a valid/ready handshake to the floor-request logic.

---
 rtl/keypad_pkg.sv | 17 +
 rtl/keypad_key_filter.sv | 44 ++++
 rtl/keypad_scanner.sv | 125 ++++++++++++
 tb/tb_keypad_scanner.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad column scanner.
package keypad_pkg;
  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, ADVANCE} state_t;

  typedef logic [3:0] key_code_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [1:0] lowest_row(input logic [NUM_ROWS-1:0] v);
    lowest_row = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (v[i]) lowest_row = 2'(i);
    end
  endfunction
endpackage

// File: rtl/keypad_key_filter.sv
// Debounce history and stable state for the four keys of one column.
module keypad_key_filter
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [NUM_ROWS-1:0] sample,
  input  logic [NUM_ROWS-1:0] set_stable,
  output logic [NUM_ROWS-1:0] candidate
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROWS; gi++) begin : g_key
      logic [DEBOUNCE_SCANS-1:0] hist_reg;
      logic [DEBOUNCE_SCANS-1:0] hist_next;
      logic                      stable_reg;

      if (DEBOUNCE_SCANS == 1) begin : g_one
        assign hist_next = sample[gi];
      end else begin : g_many
        assign hist_next = {hist_reg[DEBOUNCE_SCANS-2:0], sample[gi]};
      end

      // The current sample counts toward the run, so a press qualifies on the sample that completes it.
      assign candidate[gi] = en && (&hist_next) && !stable_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hist_reg   <= '0;
          stable_reg <= 1'b0;
        end else if (en) begin
          hist_reg <= hist_next;
          if (hist_next == '0) stable_reg <= 1'b0;
          else if (set_stable[gi]) stable_reg <= 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/keypad_scanner.sv
// Column-drive keypad scanner: walks the columns, debounces every key and
// hands each new press to the consumer through a single holding register.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_en,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic                key_valid,
  output key_code_t           key_code,
  input  logic                key_ready,
  output logic                overrun,
  input  logic                ovr_clr
);

  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  state_t              state;
  logic [1:0]          col_idx;
  logic [7:0]          settle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= '0;
      row_sync <= '0;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // The column register moves together with the state, so col stays driven through ADVANCE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      col_idx    <= 2'd0;
      settle_cnt <= 8'd0;
      col        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_en) begin
            state      <= SETTLE;
            settle_cnt <= 8'd0;
            col        <= 4'b0001 << col_idx;
          end
        end
        SETTLE: begin
          if (settle_cnt == 8'(SETTLE_CYCLES - 1)) state <= SAMPLE;
          else settle_cnt <= settle_cnt + 8'd1;
        end
        SAMPLE: state <= ADVANCE;
        ADVANCE: begin
          col_idx <= col_idx + 2'd1;
          if (scan_en) begin
            state      <= SETTLE;
            settle_cnt <= 8'd0;
            col        <= 4'b0001 << (col_idx + 2'd1);
          end else begin
            state <= IDLE;
            col   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          col   <= '0;
        end
      endcase
    end
  end

  logic [NUM_ROWS-1:0] cand     [NUM_COLS];
  logic [NUM_ROWS-1:0] set_mask [NUM_COLS];
  logic [NUM_ROWS-1:0] cur_cand;
  logic [1:0]          sel_row;
  logic                emit;
  logic                drop;

  assign cur_cand = cand[col_idx];
  assign emit     = |cur_cand;
  assign sel_row  = lowest_row(cur_cand);
  assign drop     = emit && key_valid && !key_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COLS; gi++) begin : g_col
      assign set_mask[gi] = (emit && col_idx == 2'(gi)) ? (4'b0001 << sel_row) : 4'b0000;

      keypad_key_filter #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_filter (
        .clk       (clk),
        .rst       (rst),
        .en        (state == SAMPLE && col_idx == 2'(gi)),
        .sample    (row_sync),
        .set_stable(set_mask[gi]),
        .candidate (cand[gi])
      );
    end
  endgenerate

  // A press arriving while the register is full is lost but still marked stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      overrun   <= 1'b0;
    end else begin
      if (emit && (!key_valid || key_ready)) begin
        key_code  <= {col_idx, sel_row};
        key_valid <= 1'b1;
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
      if (drop) overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        overrun;
  logic        ovr_clr;
  logic [15:0] pressed;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  logic [3:0] code_q[$];
  int         cyc_q[$];

  keypad_scanner dut (
    .clk      (clk),
    .rst      (rst),
    .scan_en  (scan_en),
    .row      (row),
    .col      (col),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Key at (c, r) is pressed[c*4+r]; it shorts column c to row r.
  always_comb begin
    row = 4'b0000;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (col[c] && pressed[c*4+r]) row[r] = 1'b1;
  end

  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      code_q.push_back(key_code);
      cyc_q.push_back(cyc);
      $display("transfer: key_code=%b cycle=%0d", key_code, cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input logic [3:0] target);
    int i;
    i = 0;
    while (col !== target && i < 100) begin
      tick();
      i++;
    end
    vectors++;
    if (col !== target) begin
      miscompares++;
      $display("FAIL wait_col: col=%b required %b within 100 cycles", col, target);
    end
  endtask

  task automatic wait_xfers(input int n, input int budget, input string name);
    int i;
    i = 0;
    while (code_q.size() < n && i < budget) begin
      tick();
      i++;
    end
    vectors++;
    if (code_q.size() < n) begin
      miscompares++;
      $display("FAIL %s: transfers=%0d required %0d within %0d cycles", name, code_q.size(), n, budget);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    rst = 1'b1; scan_en = 1'b0; key_ready = 1'b0; ovr_clr = 1'b0; pressed = '0;
    repeat (3) tick();
    vectors++; if (col !== 4'b0000) begin miscompares++; $display("FAIL reset_col: col=%b required 0000", col); end
    vectors++; if (key_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: key_valid=%b required 0", key_valid); end
    vectors++; if (key_code !== 4'b0000) begin miscompares++; $display("FAIL reset_code: key_code=%b required 0000", key_code); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: overrun=%b required 0", overrun); end
    rst = 1'b0;
    repeat (3) tick();
    vectors++; if (col !== 4'b0000) begin miscompares++; $display("FAIL idle_col: col=%b required 0000", col); end
    scan_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      exp_col = 4'b0001 << c;
      for (int k = 0; k < 6; k++) begin
        tick();
        vectors++;
        if (col !== exp_col) begin
          miscompares++;
          $display("FAIL col_walk: col=%b required %b (column %0d cycle %0d)", col, exp_col, c, k);
        end
      end
    end
    tick();
    vectors++; if (col !== 4'b0001) begin miscompares++; $display("FAIL col_wrap: col=%b required 0001", col); end
  endtask

  task automatic test_single_press();
    int t0;
    key_ready = 1'b1;
    code_q.delete(); cyc_q.delete();
    t0 = cyc;
    pressed[9] = 1'b1;
    wait_xfers(1, 100, "single_first");
    vectors++;
    if (code_q.size() < 1 || code_q[0] !== 4'b1001) begin
      miscompares++; $display("FAIL single_code: key_code=%b required 1001", (code_q.size() > 0) ? code_q[0] : 4'bxxxx);
    end
    vectors++;
    if (code_q.size() > 0 && cyc_q[0] - t0 > 76) begin
      miscompares++; $display("FAIL single_latency: latency=%0d required <= 76", cyc_q[0] - t0);
    end
    repeat (5*24) tick();
    vectors++;
    if (code_q.size() != 1) begin miscompares++; $display("FAIL single_no_repeat: transfers=%0d required 1", code_q.size()); end
    pressed[9] = 1'b0;
    repeat (3*24) tick();
    pressed[9] = 1'b1;
    wait_xfers(2, 100, "single_repress");
    vectors++;
    if (code_q.size() < 2 || code_q[1] !== 4'b1001) begin
      miscompares++; $display("FAIL single_repress_code: key_code=%b required 1001", (code_q.size() > 1) ? code_q[1] : 4'bxxxx);
    end
    pressed = '0;
    repeat (3*24) tick();
  endtask

  task automatic test_bounce();
    code_q.delete(); cyc_q.delete();
    wait_col(4'b0010);
    wait_col(4'b0100);
    pressed[9] = 1'b1;
    repeat (6) tick();
    pressed[9] = 1'b0;
    repeat (4*24) tick();
    vectors++;
    if (code_q.size() != 0 || key_valid !== 1'b0) begin
      miscompares++; $display("FAIL bounce: transfers=%0d key_valid=%b required 0 and 0", code_q.size(), key_valid);
    end
  endtask

  task automatic test_multi_press();
    code_q.delete(); cyc_q.delete();
    key_ready = 1'b1;
    pressed[1] = 1'b1;
    pressed[3] = 1'b1;
    wait_xfers(2, 130, "multi_count");
    vectors++;
    if (code_q.size() < 1 || code_q[0] !== 4'b0001) begin
      miscompares++; $display("FAIL multi_first: key_code=%b required 0001", (code_q.size() > 0) ? code_q[0] : 4'bxxxx);
    end
    vectors++;
    if (code_q.size() < 2 || code_q[1] !== 4'b0011) begin
      miscompares++; $display("FAIL multi_second: key_code=%b required 0011", (code_q.size() > 1) ? code_q[1] : 4'bxxxx);
    end
    vectors++;
    if (code_q.size() < 2 || cyc_q[1] - cyc_q[0] != 24) begin
      miscompares++; $display("FAIL multi_spacing: spacing=%0d required 24", (code_q.size() > 1) ? cyc_q[1] - cyc_q[0] : -1);
    end
    pressed = '0;
    repeat (3*24) tick();
  endtask

  task automatic test_back_to_back();
    int i;
    code_q.delete(); cyc_q.delete();
    key_ready = 1'b0;
    pressed[12] = 1'b1;
    i = 0;
    while (!key_valid && i < 100) begin tick(); i++; end
    vectors++;
    if (key_valid !== 1'b1 || key_code !== 4'b1100) begin
      miscompares++; $display("FAIL bp_first: key_valid=%b key_code=%b required 1 and 1100", key_valid, key_code);
    end
    pressed[6] = 1'b1;
    i = 0;
    while (!overrun && i < 100) begin tick(); i++; end
    vectors++;
    if (overrun !== 1'b1 || key_valid !== 1'b1 || key_code !== 4'b1100) begin
      miscompares++; $display("FAIL bp_overrun: overrun=%b key_valid=%b key_code=%b required 1 1 1100", overrun, key_valid, key_code);
    end
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    vectors++;
    if (overrun !== 1'b0) begin miscompares++; $display("FAIL bp_ovr_clr: overrun=%b required 0", overrun); end
    key_ready = 1'b1;
    tick();
    vectors++;
    if (key_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain_valid: key_valid=%b required 0", key_valid); end
    vectors++;
    if (code_q.size() != 1 || code_q[0] !== 4'b1100) begin
      miscompares++; $display("FAIL bp_drain_code: transfers=%0d required 1 of 1100", code_q.size());
    end
    repeat (3*24) tick();
    vectors++;
    if (code_q.size() != 1) begin miscompares++; $display("FAIL bp_no_repeat: transfers=%0d required 1", code_q.size()); end
    pressed = '0;
    repeat (3*24) tick();
  endtask

  task automatic test_scan_en_drop();
    wait_col(4'b0001);
    wait_col(4'b0010);
    scan_en = 1'b0;
    for (int k = 1; k < 6; k++) begin
      tick();
      vectors++;
      if (col !== 4'b0010) begin miscompares++; $display("FAIL drop_finish: col=%b required 0010 at slot cycle %0d", col, k); end
    end
    tick();
    vectors++;
    if (col !== 4'b0000) begin miscompares++; $display("FAIL drop_idle: col=%b required 0000", col); end
    repeat (3) tick();
    vectors++;
    if (col !== 4'b0000) begin miscompares++; $display("FAIL drop_hold: col=%b required 0000", col); end
    scan_en = 1'b1;
    tick();
    vectors++;
    if (col !== 4'b0100) begin miscompares++; $display("FAIL drop_resume: col=%b required 0100", col); end
  endtask

  task automatic test_async_reset();
    int i;
    code_q.delete(); cyc_q.delete();
    key_ready = 1'b0;
    pressed[0] = 1'b1;
    i = 0;
    while (!key_valid && i < 100) begin tick(); i++; end
    pressed[5] = 1'b1;
    i = 0;
    while (!overrun && i < 100) begin tick(); i++; end
    vectors++;
    if (key_valid !== 1'b1 || overrun !== 1'b1) begin
      miscompares++; $display("FAIL ar_setup: key_valid=%b overrun=%b required 1 and 1", key_valid, overrun);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (col !== 4'b0000 || key_valid !== 1'b0 || overrun !== 1'b0 || key_code !== 4'b0000) begin
      miscompares++; $display("FAIL ar_immediate: col=%b key_valid=%b overrun=%b key_code=%b required 0000 0 0 0000", col, key_valid, overrun, key_code);
    end
    pressed = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (col !== 4'b0001) begin miscompares++; $display("FAIL ar_restart: col=%b required 0001", col); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_press();
    test_back_to_back();
    test_scan_en_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
